// File: rtl/fir_sample_scheduler.sv
// fir_sample_scheduler: two-channel round-robin sample feeder and result holder for a shared FIR datapath.
// Define FIR_SCHED_TIMEOUT_EN to enable the modwait watchdog.
module fir_sample_scheduler #(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ch0_valid,
    input  logic [15:0] ch0_data,
    output logic        ch0_ready,
    input  logic        ch1_valid,
    input  logic [15:0] ch1_data,
    output logic        ch1_ready,
    output logic [15:0] sample_data,
    output logic        data_ready,
    input  logic        modwait,
    input  logic [15:0] fir_out,
    input  logic        err,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [15:0] res_data,
    output logic        res_chan,
    output logic        res_err,
    output logic        busy,
    output logic        timeout
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, HOLD} state_t;
    state_t state, state_nx;

    logic [15:0]   mem0 [FIFO_DEPTH];
    logic [15:0]   mem1 [FIFO_DEPTH];
    logic [AW-1:0] wp0, rp0, wp1, rp1;
    logic [CW-1:0] cnt0, cnt1;
    logic          push0, push1, pop0, pop1, ne0, ne1, grant, last, to_hit;

    assign ch0_ready = cnt0 != CW'(FIFO_DEPTH);
    assign ch1_ready = cnt1 != CW'(FIFO_DEPTH);
    assign push0     = ch0_valid & ch0_ready;
    assign push1     = ch1_valid & ch1_ready;
    assign ne0       = cnt0 != '0;
    assign ne1       = cnt1 != '0;
    // On a tie, the channel not served last time wins
    assign grant     = (ne0 & ne1) ? ~last : ne1;
    assign pop0      = (state == IDLE) & ne0 & ~grant;
    assign pop1      = (state == IDLE) & ne1 & grant;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp0  <= '0;
            rp0  <= '0;
            cnt0 <= '0;
            wp1  <= '0;
            rp1  <= '0;
            cnt1 <= '0;
        end else begin
            wp0  <= wp0 + AW'(push0);
            rp0  <= rp0 + AW'(pop0);
            cnt0 <= cnt0 + CW'(push0) - CW'(pop0);
            wp1  <= wp1 + AW'(push1);
            rp1  <= rp1 + AW'(pop1);
            cnt1 <= cnt1 + CW'(push1) - CW'(pop1);
        end
    end

    always_ff @(posedge clk) begin
        if (push0) mem0[wp0] <= ch0_data;
        if (push1) mem1[wp1] <= ch1_data;
    end

`ifdef FIR_SCHED_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] wd_cnt;
    logic          waiting;

    assign waiting = (state == WAIT_BUSY) | (state == WAIT_DONE);
    assign to_hit  = waiting & (wd_cnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) wd_cnt <= '0;
        else     wd_cnt <= waiting ? wd_cnt + TW'(1) : '0;
    end
`else
    assign to_hit = TIMEOUT_CYCLES < 0;
`endif

    assign timeout = to_hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:      state_nx = (ne0 | ne1) ? ISSUE : IDLE;
            ISSUE:     state_nx = WAIT_BUSY;
            WAIT_BUSY: state_nx = modwait ? WAIT_DONE : WAIT_BUSY;
            WAIT_DONE: state_nx = modwait ? WAIT_DONE : HOLD;
            HOLD:      state_nx = res_ready ? IDLE : HOLD;
            default:   state_nx = IDLE;
        endcase
        if (to_hit) state_nx = HOLD;
    end

    always_comb begin
        data_ready = state == ISSUE;
        res_valid  = state == HOLD;
        busy       = state != IDLE;
    end

    // last doubles as the owner of the in-flight sample
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sample_data <= '0;
            last        <= 1'b1;
            res_data    <= '0;
            res_chan    <= 1'b0;
            res_err     <= 1'b0;
        end else begin
            if (pop0 | pop1) begin
                sample_data <= pop1 ? mem1[rp1] : mem0[rp0];
                last        <= grant;
            end
            if (to_hit) begin
                res_data <= '0;
                res_err  <= 1'b1;
                res_chan <= last;
            end else if (state == WAIT_DONE && !modwait) begin
                res_data <= fir_out;
                res_err  <= err;
                res_chan <= last;
            end
        end
    end
endmodule
